div: RTL and testbench

Sequential restoring divider: the shift-subtract inverse of the team's shift-add `mult` core, for the same peripheral fabric. It divides a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, and returns quotient and remainder. It uses the same `init`/`done` handshake as `mult`, with `done` held long enough for a slow bus reader to sample it. It also reports division by zero.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 22 ++
 rtl/div.sv | 189 ++++++++++++++++++
 tb/tb_div.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and sizing helpers for the restoring divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 16;
    localparam int unsigned DEFAULT_DONE_HOLD = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StLoad = LOAD,
        StIter = ITER,
        StDone = DONE
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned w = value - 1; w > 0; w = w >> 1) begin
            result++;
        end
        return result;
    endfunction

    // One counter serves both the iteration phase and the done-hold phase.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned hold);
        return clog2(((width > hold) ? width : hold) + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   new_rem,
    output logic             quotient_bit
);

    logic [WIDTH+1:0] shifted;

    always_comb begin
        shifted      = {partial_rem, dividend_bit};
        quotient_bit = (shifted >= {2'b00, divisor});
        new_rem      = quotient_bit ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider, one quotient bit per clock, init/done handshake.
// Define DIV_SIGNED_EN for two's complement (truncating) division.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DONE_HOLD = DEFAULT_DONE_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    input  logic [WIDTH-1:0] op_A,
    input  logic [WIDTH-1:0] op_B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned      CNT_W     = cnt_width(WIDTH, DONE_HOLD);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(DONE_HOLD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] q_fin, r_fin;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partial_rem (prem_q),
        .dividend_bit(dvd_q[WIDTH-1]),
        .divisor     (dvs_q),
        .new_rem     (step_rem),
        .quotient_bit(step_bit)
    );

    assign quo_shift = {quo_q[WIDTH-2:0], step_bit};

`ifdef DIV_SIGNED_EN
    logic quo_neg_q, quo_neg_d;
    logic rem_neg_q, rem_neg_d;

    // Core works on magnitudes; signs are restored when the result is captured.
    assign mag_a = op_A[WIDTH-1] ? -op_A : op_A;
    assign mag_b = op_B[WIDTH-1] ? -op_B : op_B;
    assign q_fin = quo_neg_q ? -quo_shift : quo_shift;
    assign r_fin = rem_neg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];

    always_comb begin
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        if (state_q == StLoad) begin
            quo_neg_d = op_A[WIDTH-1] ^ op_B[WIDTH-1];
            rem_neg_d = op_A[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end
`else
    assign mag_a = op_A;
    assign mag_b = op_B;
    assign q_fin = quo_shift;
    assign r_fin = step_rem[WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        busy_d      = busy_q;
        div_zero_d  = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (init) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                busy_d = 1'b1;
                dvd_d  = mag_a;
                dvs_d  = mag_b;
                prem_d = '0;
                quo_d  = '0;
                cnt_d  = '0;
                if (op_B == '0) begin
                    state_d     = StDone;
                    quotient_d  = '1;
                    remainder_d = op_A;
                    div_zero_d  = 1'b1;
                end else begin
                    state_d    = StIter;
                    div_zero_d = 1'b0;
                end
            end
            StIter: begin
                dvd_d  = dvd_q << 1;
                prem_d = step_rem;
                quo_d  = quo_shift;
                if (cnt_q == LAST_ITER) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    quotient_d  = q_fin;
                    remainder_d = r_fin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // done rises one edge after entering DONE and is held DONE_HOLD cycles.
                if (cnt_q == HOLD_END) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign div_zero  = div_zero_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table, corner sequences, random ops vs a reference model.
module tb_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        done;
    logic        busy;
    logic        div_zero;
    logic [15:0] op_A;
    logic [15:0] op_B;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int checks = 0;
    int errors = 0;

    div #(
        .WIDTH    (16),
        .DONE_HOLD(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .done     (done),
        .busy     (busy),
        .div_zero (div_zero),
        .op_A     (op_A),
        .op_B     (op_B),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
        z = (b == 16'd0);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input bit disturb, input string name);
        int lat;
        int hold;
        int exp_lat;
        exp_lat = (b == 16'd0) ? 2 : 18;
        op_A = a;
        op_B = b;
        init = 1'b1;
        @(negedge clk);
        lat  = 0;
        init = 1'b0;
        check({name, "_busy_k"}, busy, 0);
        @(negedge clk);
        lat = 1;
        check({name, "_busy_k1"}, busy, 1);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (disturb && lat == 5) begin
                op_A = 16'd3;
                op_B = 16'd0;
                init = 1'b1;
            end else if (disturb && lat == 6) begin
                init = 1'b0;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_zero"}, div_zero, ez);
        hold = 0;
        while (done && hold < 100) begin
            hold++;
            @(negedge clk);
        end
        check({name, "_hold"}, hold, 10);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_q_kept"}, quotient, eq);
    endtask

    initial begin
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mz;
        logic [15:0] ra;
        logic [15:0] rb;
        int          n;
        int          lat;

        reset = 1'b1;
        init  = 1'b0;
        op_A  = 16'd0;
        op_B  = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_zero", div_zero, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);

        vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0};
        vecs[1] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
        vecs[2] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0};
        vecs[3] = '{16'h7FFF,  16'd3,     16'h2AAA,  16'd1,    1'b0};
        vecs[4] = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0};
        vecs[5] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0};
        vecs[6] = '{16'd0,     16'd0,     16'hFFFF,  16'd0,    1'b1};
        vecs[7] = '{16'd5,     16'd9,     16'd0,     16'd5,    1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // init held high across two operations
        op_A = 16'hFFFF;
        op_B = 16'd1;
        init = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", done, 1);
        check("b2b_first_q", quotient, 16'hFFFF);
        check("b2b_first_r", remainder, 16'd0);
        while (done && n < 200) begin
            @(negedge clk);
            n++;
        end
        op_A = 16'd5;
        op_B = 16'd9;
        @(negedge clk);
        init = 1'b0;
        lat  = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 18);
        check("b2b_second_q", quotient, 16'd0);
        check("b2b_second_r", remainder, 16'd5);
        n = 0;
        while (done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_hold", n, 10);

        // init pulse and operand change mid-ITER must be ignored
        run_op(16'd1000, 16'd9, 16'd111, 16'd1, 1'b0, 1'b1, "disturb");

        // reset in the middle of iteration
        op_A = 16'd100;
        op_B = 16'd7;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_zero", div_zero, 0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, "after_rst");

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, "s_m7_2");
        run_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b0, "s_min_m1");
`endif

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            model(ra, rb, mq, mr, mz);
            run_op(ra, rb, mq, mr, mz, 1'b0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
